// File: rtl/pipeif.sv
// Instruction-fetch stage: PC register, imem request handshake and IF/ID register.
// Define PIPEIF_PERF_CNT_EN to add the fetch_cnt/stall_cnt performance counters.
module pipeif #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic [1:0]  pcsource,
    input  logic [31:0] bpc,
    input  logic [31:0] jpc,
    input  logic [31:0] ra,
    input  logic        we_pc_ir,
    input  logic        reset_ir,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] pc,
    output logic [31:0] dpc4,
    output logic [31:0] inst,
    output logic        dvalid
`ifdef PIPEIF_PERF_CNT_EN
    ,
    output logic [31:0] fetch_cnt,
    output logic [31:0] stall_cnt
`endif
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_HOLD    = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    state_t          state_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] dpc4_q;
    logic [XLEN-1:0] inst_q;
    logic            dvalid_q;
    logic [XLEN-1:0] redir_q;
    logic [XLEN-1:0] buf_pc4_q;
    logic [XLEN-1:0] buf_inst_q;
    logic            req_q;

    logic [XLEN-1:0] pc4;
    logic [XLEN-1:0] npc;
    logic            ifid_ld;
    logic            ifid_valid;
    logic [XLEN-1:0] ifid_pc4;
    logic [XLEN-1:0] ifid_inst;

    assign pc4 = pc_q + XLEN'(4);

    // Next-PC select from decode
    always_comb begin
        npc = pc4;
        case (pcsource)
            2'b00:   npc = pc4;
            2'b01:   npc = bpc;
            2'b10:   npc = ra;
            default: npc = jpc;
        endcase
    end

    // IF/ID source: only a fetch hit or a held word is a real instruction, all else is a bubble
    always_comb begin
        ifid_ld    = we_pc_ir;
        ifid_valid = 1'b0;
        ifid_pc4   = pc4;
        ifid_inst  = imem_rdata;
        case (state_q)
            S_FETCH:   ifid_valid = imem_ready && !reset_ir;
            S_HOLD: begin
                ifid_valid = !reset_ir;
                ifid_pc4   = buf_pc4_q;
                ifid_inst  = buf_inst_q;
            end
            default:   ifid_valid = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clrn) begin
            state_q    <= S_FETCH;
            pc_q       <= RESET_PC;
            dpc4_q     <= '0;
            inst_q     <= '0;
            dvalid_q   <= 1'b0;
            redir_q    <= '0;
            buf_pc4_q  <= '0;
            buf_inst_q <= '0;
            req_q      <= 1'b1;
        end else begin
            if (ifid_ld) begin
                dvalid_q <= ifid_valid;
                dpc4_q   <= ifid_valid ? ifid_pc4  : '0;
                inst_q   <= ifid_valid ? ifid_inst : '0;
            end
            case (state_q)
                S_FETCH: begin
                    if (imem_ready && we_pc_ir) begin
                        pc_q <= npc;
                    end else if (imem_ready) begin
                        buf_pc4_q  <= pc4;
                        buf_inst_q <= imem_rdata;
                        state_q    <= S_HOLD;
                        req_q      <= 1'b0;
                    end else if (we_pc_ir && (pcsource != 2'b00)) begin
                        // Redirect arrived mid-fetch: the outstanding word must be drained first
                        redir_q <= npc;
                        state_q <= S_DISCARD;
                    end
                end
                S_HOLD: begin
                    if (we_pc_ir) begin
                        pc_q    <= npc;
                        state_q <= S_FETCH;
                        req_q   <= 1'b1;
                    end
                end
                S_DISCARD: begin
                    if (imem_ready) begin
                        pc_q    <= redir_q;
                        state_q <= S_FETCH;
                    end
                end
                default: begin
                    state_q <= S_FETCH;
                    req_q   <= 1'b1;
                end
            endcase
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign dpc4      = dpc4_q;
    assign inst      = inst_q;
    assign dvalid    = dvalid_q;

`ifdef PIPEIF_PERF_CNT_EN
    logic [XLEN-1:0] fetch_cnt_q;
    logic [XLEN-1:0] stall_cnt_q;

    // Free-running wrap-around event counters
    always_ff @(posedge clk) begin
        if (!clrn) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (ifid_ld && ifid_valid) begin
                fetch_cnt_q <= fetch_cnt_q + XLEN'(1);
            end
            if (req_q && !imem_ready) begin
                stall_cnt_q <= stall_cnt_q + XLEN'(1);
            end
        end
    end

    assign fetch_cnt = fetch_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipeif.sv
// Bench for pipeif: directed scenarios plus random traffic against a queue-based fetch model.
module tb_pipeif;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    typedef struct packed {
        logic        v;
        logic [31:0] pc4;
        logic [31:0] inst;
    } ent_t;

    logic        clk;
    logic        clrn;
    logic [1:0]  pcsource;
    logic [31:0] bpc, jpc, ra;
    logic        we_pc_ir, reset_ir;
    logic        imem_req;
    logic [31:0] imem_addr, imem_rdata;
    logic        imem_ready;
    logic [31:0] pc, dpc4, inst;
    logic        dvalid;
`ifdef PIPEIF_PERF_CNT_EN
    logic [31:0] fetch_cnt, stall_cnt;
`endif

    pipeif #(.RESET_PC(RST_PC)) dut (
        .clk        (clk),
        .clrn       (clrn),
        .pcsource   (pcsource),
        .bpc        (bpc),
        .jpc        (jpc),
        .ra         (ra),
        .we_pc_ir   (we_pc_ir),
        .reset_ir   (reset_ir),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_ready (imem_ready),
        .pc         (pc),
        .dpc4       (dpc4),
        .inst       (inst),
        .dvalid     (dvalid)
`ifdef PIPEIF_PERF_CNT_EN
        ,
        .fetch_cnt  (fetch_cnt),
        .stall_cnt  (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    ent_t        exp_q[$];
    ent_t        hold_m[$];
    logic [31:0] redir_m[$];
    logic [31:0] pc_m;
    logic        req_m;
    logic [31:0] fcnt_m, scnt_m;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return ((a * 32'h9E37_79B1) ^ 32'h1357_9BDF) | 32'h1;
    endfunction

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // One clock of stimulus; the model predicts the state after the coming edge
    task automatic step(input logic rn, input logic we, input logic rir, input logic rdy,
                        input logic [1:0] pcs);
        ent_t        e;
        ent_t        f;
        logic [31:0] np;
        clrn       = rn;
        we_pc_ir   = we;
        reset_ir   = rir;
        imem_ready = rdy;
        pcsource   = pcs;
        imem_rdata = rdy ? mem(imem_addr) : $urandom();
        case (pcs)
            2'b00:   np = pc_m + 32'd4;
            2'b01:   np = bpc;
            2'b10:   np = ra;
            default: np = jpc;
        endcase
        e = '0;
        f = '{1'b1, pc_m + 32'd4, mem(pc_m)};
        if (!rn) begin
            exp_q.push_back(e);
            pc_m = RST_PC;
            hold_m.delete();
            redir_m.delete();
            fcnt_m = '0;
            scnt_m = '0;
        end else begin
            if (req_m && !rdy) scnt_m++;
            if (hold_m.size() != 0) begin
                if (we) begin
                    if (!rir) e = hold_m[0];
                    exp_q.push_back(e);
                    hold_m.delete();
                    pc_m = np;
                end
            end else if (redir_m.size() != 0) begin
                if (we) exp_q.push_back(e);
                if (rdy) pc_m = redir_m.pop_front();
            end else if (rdy) begin
                if (we) begin
                    if (!rir) e = f;
                    exp_q.push_back(e);
                    pc_m = np;
                end else begin
                    hold_m.push_back(f);
                end
            end else if (we) begin
                exp_q.push_back(e);
                if (pcs != 2'b00) redir_m.push_back(np);
            end
            if (e.v) fcnt_m++;
        end
        req_m = (hold_m.size() == 0);
        @(posedge clk);
        #1;
        chk("pc", pc, pc_m);
        chk("imem_req", 32'(imem_req), 32'(req_m));
        chk("imem_addr", imem_addr, pc_m);
    endtask

    // Monitor: pops an expectation on every IF/ID load, otherwise expects IF/ID to hold
    ent_t last_m = '0;
    always begin
        logic ld;
        ent_t e;
        @(posedge clk);
        ld = (clrn === 1'b0) || (we_pc_ir === 1'b1);
        #2;
        if (ld) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL scoreboard: IF/ID load with no expectation at %0t", $time);
            end else begin
                last_m = exp_q.pop_front();
            end
        end
        e = last_m;
        chk("dvalid", 32'(dvalid), 32'(e.v));
        chk("dpc4", dpc4, e.pc4);
        chk("inst", inst, e.inst);
    end

    initial begin
        pc_m = RST_PC; req_m = 1'b1; fcnt_m = '0; scnt_m = '0;
        bpc = 32'h100; jpc = 32'hFFFF_FFFC; ra = 32'h40;

        // Reset, then sequential hits
        step(0, 0, 0, 0, 0);
        chk("rst_addr", imem_addr, RST_PC);
        chk("rst_req", 32'(imem_req), 32'd1);
        chk("rst_dvalid", 32'(dvalid), 32'd0);
        step(1, 1, 0, 1, 0);
        chk("seq_addr4", imem_addr, 32'h4);
        chk("seq_dpc4_4", dpc4, 32'h4);
        step(1, 1, 0, 1, 0);
        chk("seq_addr8", imem_addr, 32'h8);
        chk("seq_dpc4_8", dpc4, 32'h8);
        step(1, 1, 0, 1, 0);
        step(1, 1, 0, 1, 0);

        // Stall with data ready at pc=0x10
        repeat (3) begin
            step(1, 0, 0, 1, 0);
            chk("hold_pc", pc, 32'h10);
            chk("hold_req", 32'(imem_req), 32'd0);
        end
        step(1, 1, 0, 0, 0);
        chk("hold_inst", inst, mem(32'h10));
        chk("hold_pc_rel", pc, 32'h14);
        repeat (3) step(1, 1, 0, 0, 0);
`ifdef PIPEIF_PERF_CNT_EN
        chk("fetch_cnt5", fetch_cnt, 32'd5);
        chk("stall_cnt3", stall_cnt, 32'd3);
`endif

        // Flush on hit, then flush ignored during stall
        step(1, 1, 1, 1, 0);
        chk("flush_inst", inst, 32'h0);
        chk("flush_dvalid", 32'(dvalid), 32'd0);
        chk("flush_pc", pc, 32'h18);
        step(1, 1, 0, 1, 0);
        step(1, 0, 1, 0, 0);
        chk("flush_stall_inst", inst, mem(32'h18));
        chk("flush_stall_dvalid", 32'(dvalid), 32'd1);
        step(1, 1, 0, 1, 0);

        // Branch during a miss at pc=0x20: outstanding word dropped
        step(1, 1, 0, 0, 1);
        chk("disc_dvalid", 32'(dvalid), 32'd0);
        step(1, 1, 0, 0, 0);
        chk("disc_addr", imem_addr, 32'h20);
        step(1, 1, 0, 1, 0);
        chk("disc_redir", imem_addr, 32'h100);
        chk("disc_drop", 32'(dvalid), 32'd0);
        step(1, 1, 0, 1, 0);
        chk("disc_tgt_inst", inst, mem(32'h100));

        // PC wrap and reset during HOLD
        step(1, 1, 0, 1, 3);
        step(1, 1, 0, 1, 0);
        chk("wrap_pc", pc, 32'h0);
        chk("wrap_dpc4", dpc4, 32'h0);
        step(1, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        chk("hrst_pc", pc, RST_PC);
        chk("hrst_dvalid", 32'(dvalid), 32'd0);
        chk("hrst_req", 32'(imem_req), 32'd1);
        step(1, 1, 0, 1, 0);
        chk("hrst_inst", inst, mem(RST_PC));

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            bpc = $urandom() & ~32'h3;
            jpc = $urandom() & ~32'h3;
            ra  = $urandom() & ~32'h3;
            step(logic'($urandom_range(63) != 0), logic'($urandom_range(3) != 0),
                 logic'($urandom_range(7) == 0), logic'($urandom_range(2) != 0),
                 2'($urandom_range(3)));
        end
`ifdef PIPEIF_PERF_CNT_EN
        chk("fetch_cnt_rand", fetch_cnt, fcnt_m);
        chk("stall_cnt_rand", stall_cnt, scnt_m);
`endif
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
